alu_issue_ctrl: RTL

//  Shares the single clocked ALU between the two superscalar issue slots (req0, req1).

---
 rtl/alu_ctrl_pkg.sv | 26 ++
 rtl/rr_arbiter2.sv | 21 ++
 rtl/alu_issue_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU issue controller: op bit indices, FSM states, default widths.
package alu_ctrl_pkg;

    localparam int unsigned OpAdd = 0;
    localparam int unsigned OpSub = 3;
    localparam int unsigned OpMul = 4;
    localparam int unsigned OpMov = 6;
    localparam int unsigned OpAnd = 8;
    localparam int unsigned OpNot = 9;
    localparam int unsigned OpLsl = 10;
    localparam int unsigned OpLsr = 11;

    localparam int unsigned DefDataW  = 16;
    localparam int unsigned DefSigW   = 12;
    localparam int unsigned DefImmW   = 5;
    localparam int unsigned DefTagW   = 4;
    localparam int unsigned DefAluLat = 1;
    localparam int unsigned DefMulLat = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a sole requester wins; on a tie the slot not named by rr_ptr_i wins.
module rr_arbiter2 (
    input  logic       en_i,
    input  logic [1:0] valid_i,
    input  logic       rr_ptr_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        if (en_i) begin
            case (valid_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = rr_ptr_i ? 2'b01 : 2'b10;
                default: grant_o = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Shares one clocked ALU between two issue slots: arbitrate, hold operands, return tagged result.
// Optional one-hot op checking with err_illegal_o is enabled by defining ALU_ONEHOT_CHECK_EN.
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = DefDataW,
    parameter int unsigned SIG_W   = DefSigW,
    parameter int unsigned IMM_W   = DefImmW,
    parameter int unsigned TAG_W   = DefTagW,
    parameter int unsigned ALU_LAT = DefAluLat,
    parameter int unsigned MUL_LAT = DefMulLat
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [SIG_W-1:0]  req0_sig_i,
    input  logic [DATA_W-1:0] req0_op1_i,
    input  logic [DATA_W-1:0] req0_op2_i,
    input  logic [IMM_W-1:0]  req0_immx_i,
    input  logic              req0_isimm_i,
    input  logic [TAG_W-1:0]  req0_tag_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [SIG_W-1:0]  req1_sig_i,
    input  logic [DATA_W-1:0] req1_op1_i,
    input  logic [DATA_W-1:0] req1_op2_i,
    input  logic [IMM_W-1:0]  req1_immx_i,
    input  logic              req1_isimm_i,
    input  logic [TAG_W-1:0]  req1_tag_i,
    output logic [SIG_W-1:0]  alu_sig_o,
    output logic [DATA_W-1:0] alu_op1_o,
    output logic [DATA_W-1:0] alu_op2_o,
    output logic [IMM_W-1:0]  alu_immx_o,
    output logic              alu_isimm_o,
    input  logic [DATA_W-1:0] alu_result_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [DATA_W-1:0] res_data_o,
    output logic [TAG_W-1:0]  res_tag_o,
    output logic              res_src_o
`ifdef ALU_ONEHOT_CHECK_EN
    ,
    output logic              err_illegal_o
`endif
);

    localparam int unsigned MaxLat = (ALU_LAT > MUL_LAT) ? ALU_LAT : MUL_LAT;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);

    state_e              state_q, state_d;
    logic                rr_ptr_q, rr_ptr_d;
    logic                granted_q, granted_d;
    logic [SIG_W-1:0]    sig_q, sig_d;
    logic [DATA_W-1:0]   op1_q, op1_d, op2_q, op2_d, data_q, data_d;
    logic [IMM_W-1:0]    immx_q, immx_d;
    logic                isimm_q, isimm_d, src_q, src_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [1:0]          grant;
    logic                arb_en, arb_ptr, hs, sel;
    logic [SIG_W-1:0]    sel_sig;
`ifdef ALU_ONEHOT_CHECK_EN
    logic                err_q, err_d;
`endif

    // Readies are masked while reset is held so a waiting requester never sees a grant.
    assign arb_en  = (state_q == StIdle) && rst_n;
    // Before the first grant pretend slot 1 went last, so req0 wins the first tie.
    assign arb_ptr = granted_q ? rr_ptr_q : 1'b1;

    rr_arbiter2 u_arb (
        .en_i     (arb_en),
        .valid_i  ({req1_valid_i, req0_valid_i}),
        .rr_ptr_i (arb_ptr),
        .grant_o  (grant)
    );

    assign req0_ready_o = grant[0];
    assign req1_ready_o = grant[1];
    assign hs      = (grant[0] && req0_valid_i) || (grant[1] && req1_valid_i);
    assign sel     = grant[1];
    assign sel_sig = sel ? req1_sig_i : req0_sig_i;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        granted_d = granted_q;
        sig_d     = sig_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        immx_d    = immx_q;
        isimm_d   = isimm_q;
        tag_d     = tag_q;
        src_d     = src_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
`ifdef ALU_ONEHOT_CHECK_EN
        err_d     = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (hs) begin
                    sig_d     = sel_sig;
                    op1_d     = sel ? req1_op1_i : req0_op1_i;
                    op2_d     = sel ? req1_op2_i : req0_op2_i;
                    immx_d    = sel ? req1_immx_i : req0_immx_i;
                    isimm_d   = sel ? req1_isimm_i : req0_isimm_i;
                    tag_d     = sel ? req1_tag_i : req0_tag_i;
                    src_d     = sel;
                    rr_ptr_d  = sel;
                    granted_d = 1'b1;
                    cnt_d     = sel_sig[OpMul] ? CntW'(MUL_LAT) : CntW'(ALU_LAT);
                    state_d   = StExec;
`ifdef ALU_ONEHOT_CHECK_EN
                    if ($countones(sel_sig) != 1) begin
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
`endif
                end
            end
            StExec: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    data_d  = alu_result_i;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (res_ready_i) begin
                    state_d = StIdle;
`ifdef ALU_ONEHOT_CHECK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rr_ptr_q  <= 1'b0;
            granted_q <= 1'b0;
            sig_q     <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            immx_q    <= '0;
            isimm_q   <= 1'b0;
            tag_q     <= '0;
            src_q     <= 1'b0;
            cnt_q     <= '0;
            data_q    <= '0;
`ifdef ALU_ONEHOT_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            granted_q <= granted_d;
            sig_q     <= sig_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            immx_q    <= immx_d;
            isimm_q   <= isimm_d;
            tag_q     <= tag_d;
            src_q     <= src_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
`ifdef ALU_ONEHOT_CHECK_EN
            err_q     <= err_d;
`endif
        end
    end

    assign alu_sig_o   = (state_q == StExec) ? sig_q : '0;
    assign alu_op1_o   = op1_q;
    assign alu_op2_o   = op2_q;
    assign alu_immx_o  = immx_q;
    assign alu_isimm_o = isimm_q;
    assign res_valid_o = (state_q == StResp);
    assign res_data_o  = data_q;
    assign res_tag_o   = tag_q;
    assign res_src_o   = src_q;
`ifdef ALU_ONEHOT_CHECK_EN
    assign err_illegal_o = err_q;
`endif

endmodule
